session_key_ctrl: RTL

Parametrised key-lifecycle controller for the receiving abonent. It loads the long key from the password container and runs repeated Diffie-Hellman session-key exchanges, counting the decrypted blocks the user consumes. It rekeys the session every SESSION_BLOCKS blocks and forces a long-key change every SESSIONS_PER_LONG sessions. It also adds a DH/long-key timeout with an error state and an abort path, and drives the key/key_valid pair shared by the AES encryptor and decryptor.

---
 rtl/session_key_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/session_key_ctrl.sv
// Key-lifecycle controller for the receiving side: long-key load, repeated DH session rekeys,
// forced long-key change, DH/long-key timeout with an error state and an abort path.
module session_key_ctrl #(
  parameter int               KEY_W             = 128,
  parameter int               SESSION_BLOCKS    = 16,
  parameter int               SESSIONS_PER_LONG = 4,
  parameter int               DH_TIMEOUT        = 1024,
  parameter logic [KEY_W-1:0] INITIAL_LONG_KEY  = KEY_W'(130),
  localparam int              BW                = $clog2(SESSION_BLOCKS),
  localparam int              SW                = $clog2(SESSIONS_PER_LONG),
  localparam int              TW                = $clog2(DH_TIMEOUT)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             transmit_req_i,
  input  logic             abort_i,
  input  logic [KEY_W-1:0] lk_in_i,
  input  logic             lk_valid_i,
  input  logic             usr_long_key_ch_i,
  input  logic [KEY_W-1:0] dh_key_in_i,
  input  logic             dh_key_valid_i,
  input  logic             blk_done_i,
  output logic [KEY_W-1:0] key_out_o,
  output logic             key_valid_o,
  output logic             dh_start_o,
  output logic             lk_ch_req_o,
  output logic [KEY_W-1:0] lk_next_o,
  output logic             usr_long_key_change_rq_o,
  output logic             ready_for_transmit_o,
  output logic             timeout_err_o,
  output logic [2:0]       state_o,
  output logic [BW-1:0]    blk_cnt_o,
  output logic [SW-1:0]    session_cnt_o
);

  // IDLE: link closed | DH_EXCH: waiting session key | ACTIVE: counting blocks |
  // LONG_CH: waiting user ack | LONG_WAIT: waiting container reload | ERROR: timed out
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DH_EXCH   = 3'd1,
    S_ACTIVE    = 3'd2,
    S_LONG_CH   = 3'd3,
    S_LONG_WAIT = 3'd4,
    S_ERROR     = 3'd5
  } state_e;

  localparam logic [BW-1:0] BLK_LAST = BW'(SESSION_BLOCKS - 1);
  localparam logic [SW-1:0] SES_LAST = SW'(SESSIONS_PER_LONG - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(DH_TIMEOUT - 1);

  state_e           state_q;
  logic [KEY_W-1:0] key_out_q;
  logic             key_valid_q;
  logic             dh_start_q;
  logic             lk_ch_req_q;
  logic [KEY_W-1:0] lk_next_q;
  logic             change_rq_q;
  logic [BW-1:0]    blk_cnt_q;
  logic [SW-1:0]    session_cnt_q;
  logic [TW-1:0]    timer_q;
  logic             lk_valid_prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= S_IDLE;
      key_out_q       <= '0;
      key_valid_q     <= 1'b0;
      dh_start_q      <= 1'b0;
      lk_ch_req_q     <= 1'b0;
      lk_next_q       <= INITIAL_LONG_KEY;
      change_rq_q     <= 1'b0;
      blk_cnt_q       <= '0;
      session_cnt_q   <= '0;
      timer_q         <= '0;
      lk_valid_prev_q <= 1'b0;
    end else begin
      dh_start_q      <= 1'b0;
      lk_ch_req_q     <= 1'b0;
      lk_valid_prev_q <= lk_valid_i;
      // abort keeps lk_next and key_out so the container and cores see stable values
      if (abort_i && state_q != S_IDLE) begin
        state_q       <= S_IDLE;
        key_valid_q   <= 1'b0;
        blk_cnt_q     <= '0;
        session_cnt_q <= '0;
        timer_q       <= '0;
        change_rq_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (transmit_req_i && lk_valid_i) begin
              state_q     <= S_DH_EXCH;
              key_out_q   <= lk_in_i;
              key_valid_q <= 1'b1;
              dh_start_q  <= 1'b1;
              timer_q     <= '0;
            end
          end
          S_DH_EXCH: begin
            timer_q <= timer_q + 1'b1;
            if (dh_key_valid_i) begin
              state_q   <= S_ACTIVE;
              key_out_q <= dh_key_in_i;
              blk_cnt_q <= '0;
            end else if (timer_q == TMR_LAST) begin
              state_q     <= S_ERROR;
              key_valid_q <= 1'b0;
            end
          end
          S_ACTIVE: begin
            if (blk_done_i) begin
              if (blk_cnt_q == BLK_LAST) begin
                blk_cnt_q <= '0;
                if (session_cnt_q == SES_LAST) begin
                  session_cnt_q <= '0;
                  key_valid_q   <= 1'b0;
                  change_rq_q   <= 1'b1;
                  state_q       <= S_LONG_CH;
                end else begin
                  session_cnt_q <= session_cnt_q + 1'b1;
                  key_out_q     <= lk_in_i;
                  dh_start_q    <= 1'b1;
                  timer_q       <= '0;
                  state_q       <= S_DH_EXCH;
                end
              end else begin
                blk_cnt_q <= blk_cnt_q + 1'b1;
              end
            end
          end
          S_LONG_CH: begin
            if (usr_long_key_ch_i) begin
              lk_next_q   <= lk_next_q + 1'b1;
              lk_ch_req_q <= 1'b1;
              change_rq_q <= 1'b0;
              timer_q     <= '0;
              state_q     <= S_LONG_WAIT;
            end
          end
          S_LONG_WAIT: begin
            timer_q <= timer_q + 1'b1;
            if (lk_valid_i && !lk_valid_prev_q) begin
              state_q <= S_IDLE;
            end else if (timer_q == TMR_LAST) begin
              state_q     <= S_ERROR;
              key_valid_q <= 1'b0;
            end
          end
          S_ERROR: key_valid_q <= 1'b0;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign key_out_o                = key_out_q;
  assign key_valid_o              = key_valid_q;
  assign dh_start_o               = dh_start_q;
  assign lk_ch_req_o              = lk_ch_req_q;
  assign lk_next_o                = lk_next_q;
  assign usr_long_key_change_rq_o = change_rq_q;
  assign ready_for_transmit_o     = (state_q == S_IDLE);
  assign timeout_err_o            = (state_q == S_ERROR);
  assign state_o                  = state_q;
  assign blk_cnt_o                = blk_cnt_q;
  assign session_cnt_o            = session_cnt_q;

endmodule
